mips_seq_ctrl: RTL

//  Multi-cycle sequencer for the 32-word MIPS-like datapath: owns the PC, fetches from program memory via REQ/ACK,

---
 rtl/mips_ctrl_pkg.sv | 26 ++
 rtl/mips_ctrl_decode.sv | 52 +++++
 rtl/mips_seq_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-like sequencer.
// Covers the opcode and funct values, the FSM state type and immediate sign extension.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_HALT  = 6'd63;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd2;
  localparam logic [5:0] FN_XOR = 6'd10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction decoder: splits the held IR into GPR addresses and ALU controls,
// and classifies the word as legal, HALT, or neither.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  regnum0,
  output logic [4:0]  regnum1,
  output logic [4:0]  regnum2,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        alusrc,
  output logic [31:0] imm,
  output logic        legal,
  output logic        is_halt
);

  assign opcode  = ir[31:26];
  assign funct   = ir[5:0];
  assign regnum0 = ir[25:21];
  assign regnum1 = ir[20:16];
  assign imm     = sign_ext16(ir[15:0]);

  // Destination select and legality check per opcode
  always_comb begin
    regnum2 = 5'd0;
    alusrc  = 1'b0;
    legal   = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        regnum2 = ir[15:11];
        case (funct)
          FN_ADD, FN_SUB, FN_XOR: legal = 1'b1;
          default:                legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        regnum2 = ir[20:16];
        alusrc  = 1'b1;
        legal   = 1'b1;
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle FETCH-DECODE-EXEC-WB sequencer owning the PC, IR, fetch wait counter,
// sticky halt-cause flags and the retired-instruction counter.
module mips_seq_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 15,
  parameter int RET_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RUN,
  input  logic [31:0]       INST,
  input  logic              IMEM_ACK,
  input  logic              ALU_FLAG,
  output logic [ADDR_W-1:0] PC,
  output logic              IMEM_REQ,
  output logic [4:0]        REGNUM0,
  output logic [4:0]        REGNUM1,
  output logic [4:0]        REGNUM2,
  output logic              WE0,
  output logic [5:0]        OPCODE,
  output logic [5:0]        FUNCT,
  output logic              ALUSRC,
  output logic [31:0]       IMM,
  output logic              BUSY,
  output logic              HALTED,
  output logic              ILLEGAL,
  output logic              TIMEOUT,
  output logic              OVF,
  output logic [RET_W-1:0]  RETIRED
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   pc_r;
  logic [31:0]         ir_r;
  logic [WAIT_W-1:0]   wait_r;
  logic                illegal_r;
  logic                timeout_r;
  logic                ovf_r;
  logic [RET_W-1:0]    retired_r;

  logic                load_ir_s;
  logic                wait_inc_s;
  logic                set_ill_s;
  logic                set_to_s;
  logic                wb_s;
  logic                restart_s;

  logic [4:0]          regnum0_s;
  logic [4:0]          regnum1_s;
  logic [4:0]          regnum2_s;
  logic [5:0]          opcode_s;
  logic [5:0]          funct_s;
  logic                alusrc_s;
  logic [31:0]         imm_s;
  logic                legal_s;
  logic                is_halt_s;

  mips_ctrl_decode u_decode (
    .ir      (ir_r),
    .regnum0 (regnum0_s),
    .regnum1 (regnum1_s),
    .regnum2 (regnum2_s),
    .opcode  (opcode_s),
    .funct   (funct_s),
    .alusrc  (alusrc_s),
    .imm     (imm_s),
    .legal   (legal_s),
    .is_halt (is_halt_s)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and per-state datapath strobes
  always_comb begin
    state_s    = state_r;
    load_ir_s  = 1'b0;
    wait_inc_s = 1'b0;
    set_ill_s  = 1'b0;
    set_to_s   = 1'b0;
    wb_s       = 1'b0;
    restart_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (RUN) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (IMEM_ACK) begin
          load_ir_s = 1'b1;
          state_s   = ST_DECODE;
        end else if (wait_r == WAIT_W'(MAX_WAIT - 1)) begin
          set_to_s = 1'b1;
          state_s  = ST_HALT;
        end else begin
          wait_inc_s = 1'b1;
          state_s    = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (is_halt_s) begin
          state_s = ST_HALT;
        end else if (!legal_s) begin
          set_ill_s = 1'b1;
          state_s   = ST_HALT;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_s = ST_WB;
      end
      ST_WB: begin
        wb_s    = 1'b1;
        state_s = ST_FETCH;
      end
      ST_HALT: begin
        if (RUN) begin
          restart_s = 1'b1;
          state_s   = ST_FETCH;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // PC, IR, wait counter, sticky flags and retire count
  always_ff @(posedge CLK) begin
    if (!RST) begin
      pc_r      <= '0;
      ir_r      <= 32'd0;
      wait_r    <= '0;
      illegal_r <= 1'b0;
      timeout_r <= 1'b0;
      ovf_r     <= 1'b0;
      retired_r <= '0;
    end else begin
      if (load_ir_s) begin
        ir_r <= INST;
      end
      // Wait count only lives inside FETCH; any other state rearms it.
      if (state_r != ST_FETCH) begin
        wait_r <= '0;
      end else if (wait_inc_s) begin
        wait_r <= wait_r + WAIT_W'(1);
      end
      if (restart_s) begin
        pc_r      <= '0;
        illegal_r <= 1'b0;
        timeout_r <= 1'b0;
        ovf_r     <= 1'b0;
        retired_r <= '0;
      end else begin
        if (wb_s) begin
          pc_r      <= pc_r + ADDR_W'(1);
          ovf_r     <= ovf_r | ALU_FLAG;
          retired_r <= retired_r + RET_W'(1);
        end
        if (set_ill_s) begin
          illegal_r <= 1'b1;
        end
        if (set_to_s) begin
          timeout_r <= 1'b1;
        end
      end
    end
  end

  assign PC       = pc_r;
  assign IMEM_REQ = (state_r == ST_FETCH);
  assign WE0      = (state_r == ST_WB) && (regnum2_s != 5'd0);
  assign BUSY     = (state_r != ST_IDLE) && (state_r != ST_HALT);
  assign HALTED   = (state_r == ST_HALT);
  assign ILLEGAL  = illegal_r;
  assign TIMEOUT  = timeout_r;
  assign OVF      = ovf_r;
  assign RETIRED  = retired_r;
  assign REGNUM0  = regnum0_s;
  assign REGNUM1  = regnum1_s;
  assign REGNUM2  = regnum2_s;
  assign OPCODE   = opcode_s;
  assign FUNCT    = funct_s;
  assign ALUSRC   = alusrc_s;
  assign IMM      = imm_s;

endmodule
